// File: rtl/wbr_pkg.sv
// wbr_pkg: shared definitions for the wrapper boundary register.
//   - wrapper mode encoding (2-bit) and named mode constants
//   - cnt_width(): width of a counter that must hold 0..len+1
package wbr_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_FUNC   = 2'b00;
  localparam mode_t MODE_INTEST = 2'b01;
  localparam mode_t MODE_EXTEST = 2'b10;
  localparam mode_t MODE_SAFE   = 2'b11;

  // Shift counter saturates at len+1, so it needs len+2 distinct values.
  function automatic int cnt_width(input int len);
    return $clog2(len + 2);
  endfunction

endpackage

// File: rtl/wbr_cell.sv
// wbr_cell: one boundary-register cell (shift flop + update flop).
// Ports:
//   clk, resetn     clock, synchronous active-low reset
//   shift_en        load shift flop from si
//   capture_en      load shift flop from cap_d
//   update_en       copy shift flop into update flop
//   si, cap_d       serial and parallel data in
//   so              shift flop (feeds next cell toward scan out)
//   q               update flop (drives the mode mux in the top)
// Enables arrive already arbitrated by the top, so at most one is high.
import wbr_pkg::*;

module wbr_cell #(
  parameter logic RST_U = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic shift_en,
  input  logic capture_en,
  input  logic update_en,
  input  logic si,
  input  logic cap_d,
  output logic so,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      so <= 1'b0;
      q  <= RST_U;
    end else begin
      if (shift_en)        so <= si;
      else if (capture_en) so <= cap_d;
      if (update_en)       q  <= so;
    end
  end

endmodule

// File: rtl/wbr_param.sv
// wbr_param: parametrised wrapper boundary register.
// One chain of NUM_OUT core-output cells (chain positions 0..NUM_OUT-1)
// followed by NUM_IN core-input cells. Scan path: WPSI -> cell L-1 -> ...
// -> cell 0 -> WPSO.
// Ports:
//   CLK, resetn                  clock, synchronous active-low reset
//   WPSI / WPSO                  serial scan in / out
//   shift_wr/capture_wr/update_wr  wrapper strobes (shift > capture > update)
//   mode                         00 func, 01 intest, 10 extest, 11 safe
//   BusDisable                   forces OE_MASK cells' pad_oe low
//   core_out/pad_out/pad_oe      core-output side
//   pad_in/core_in               core-input side
//   proto_err, len_err           sticky error flags, cleared only by reset
import wbr_pkg::*;

module wbr_param #(
  parameter int                  NUM_OUT  = 4,
  parameter int                  NUM_IN   = 3,
  parameter logic [NUM_OUT-1:0]  OE_MASK  = 4'b1000,
  parameter logic [NUM_OUT-1:0]  SAFE_OUT = '0,
  parameter logic [NUM_IN-1:0]   SAFE_IN  = '0
) (
  input  logic               CLK,
  input  logic               resetn,
  input  logic               WPSI,
  output logic               WPSO,
  input  logic               shift_wr,
  input  logic               capture_wr,
  input  logic               update_wr,
  input  logic [1:0]         mode,
  input  logic               BusDisable,
  input  logic [NUM_OUT-1:0] core_out,
  output logic [NUM_OUT-1:0] pad_out,
  output logic [NUM_OUT-1:0] pad_oe,
  input  logic [NUM_IN-1:0]  pad_in,
  output logic [NUM_IN-1:0]  core_in,
  output logic               proto_err,
  output logic               len_err
);

  localparam int             L     = NUM_OUT + NUM_IN;
  localparam int             CW    = cnt_width(L);
  localparam logic [L-1:0]   U_RST = {SAFE_IN, SAFE_OUT};

  logic [L-1:0]  sreg, ureg, cap_vec;
  logic [CW-1:0] shift_cnt;
  logic          do_shift, do_cap, do_upd, multi;

  // Only the highest-priority strobe executes.
  assign do_shift = shift_wr;
  assign do_cap   = capture_wr & ~shift_wr;
  assign do_upd   = update_wr & ~shift_wr & ~capture_wr;
  assign multi    = (shift_wr & capture_wr) | (shift_wr & update_wr) |
                    (capture_wr & update_wr);

  assign cap_vec  = {pad_in, core_out};

  genvar i;
  generate
    for (i = 0; i < L; i++) begin : g_cell
      logic si;
      if (i == L-1) begin : g_head
        assign si = WPSI;
      end else begin : g_body
        assign si = sreg[i+1];
      end
      wbr_cell #(.RST_U(U_RST[i])) u_cell (
        .clk        (CLK),
        .resetn     (resetn),
        .shift_en   (do_shift),
        .capture_en (do_cap),
        .update_en  (do_upd),
        .si         (si),
        .cap_d      (cap_vec[i]),
        .so         (sreg[i]),
        .q          (ureg[i])
      );
    end
  endgenerate

  // sreg[0] is already a flop, so scan out is registered with no extra stage.
  assign WPSO = sreg[0];

  // Shift counter and sticky error flags.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      shift_cnt <= '0;
      proto_err <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      if (multi)                              proto_err <= 1'b1;
      if (do_upd && shift_cnt != CW'(L))      len_err   <= 1'b1;
      if (do_shift) begin
        if (shift_cnt != CW'(L+1))            shift_cnt <= shift_cnt + CW'(1);
      end else if (do_cap || do_upd) begin
        shift_cnt <= '0;
      end
    end
  end

  // Mode mux: purely combinational, never touches sreg/ureg.
  always_comb begin
    pad_out = core_out;
    core_in = pad_in;
    case (mode_t'(mode))
      MODE_INTEST: begin
        pad_out = SAFE_OUT;
        core_in = ureg[L-1:NUM_OUT];
      end
      MODE_EXTEST: begin
        pad_out = ureg[NUM_OUT-1:0];
        core_in = SAFE_IN;
      end
      MODE_SAFE: begin
        pad_out = SAFE_OUT;
        core_in = SAFE_IN;
      end
      default: ;
    endcase
  end

  logic oe_gate;
  assign oe_gate = BusDisable | (mode_t'(mode) == MODE_SAFE);
  assign pad_oe  = ~(OE_MASK & {NUM_OUT{oe_gate}});

endmodule

// File: tb/tb_wbr_param.sv
module tb_wbr_param;

  localparam int L = 7;

  logic       CLK = 1'b0;
  logic       resetn = 1'b1;
  logic       WPSI = 1'b0;
  logic       WPSO;
  logic       shift_wr = 1'b0, capture_wr = 1'b0, update_wr = 1'b0;
  logic [1:0] mode = 2'b11;
  logic       BusDisable = 1'b0;
  logic [3:0] core_out = 4'h0;
  logic [3:0] pad_out, pad_oe;
  logic [2:0] pad_in = 3'b000;
  logic [2:0] core_in;
  logic       proto_err, len_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard of the scan chain: exp_q[k] is the bit that WPSO must show
  // after k more shifts. Capture/reset refill it; each shift pushes WPSI.
  bit exp_q[$];

  wbr_param dut (
    .CLK(CLK), .resetn(resetn), .WPSI(WPSI), .WPSO(WPSO),
    .shift_wr(shift_wr), .capture_wr(capture_wr), .update_wr(update_wr),
    .mode(mode), .BusDisable(BusDisable),
    .core_out(core_out), .pad_out(pad_out), .pad_oe(pad_oe),
    .pad_in(pad_in), .core_in(core_in),
    .proto_err(proto_err), .len_err(len_err)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input logic s, input logic c, input logic u, input logic w);
    @(negedge CLK);
    shift_wr = s; capture_wr = c; update_wr = u; WPSI = w;
    @(posedge CLK);
    #1;
    shift_wr = 1'b0; capture_wr = 1'b0; update_wr = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    exp_q.delete();
    for (int i = 0; i < L; i++) exp_q.push_back(1'b0);
  endtask

  task automatic sh(input logic w);
    tick(1'b1, 1'b0, 1'b0, w);
    exp_q.push_back(w);
    void'(exp_q.pop_front());
  endtask

  task automatic cap();
    logic [6:0] v;
    v = {pad_in, core_out};
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    exp_q.delete();
    for (int i = 0; i < L; i++) exp_q.push_back(v[i]);
  endtask

  task automatic upd();
    tick(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic shift_word(input logic [6:0] v);
    for (int i = 0; i < L; i++) sh(v[i]);
  endtask

  task automatic test_reset();
    mode = 2'b11; core_out = 4'hF; pad_in = 3'b111;
    do_reset();
    sh(1'b1); sh(1'b1);
    // reset must win over all three strobes asserted together
    resetn = 1'b0;
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    resetn = 1'b1;
    exp_q.delete();
    for (int i = 0; i < L; i++) exp_q.push_back(1'b0);
    n_cmp++; if (pad_out !== 4'h0)    begin n_bad++; $display("FAIL reset_pad_out got %h want %h", pad_out, 4'h0); end
    n_cmp++; if (pad_oe !== 4'b0111)  begin n_bad++; $display("FAIL reset_pad_oe got %b want %b", pad_oe, 4'b0111); end
    n_cmp++; if (core_in !== 3'b000)  begin n_bad++; $display("FAIL reset_core_in got %b want %b", core_in, 3'b000); end
    n_cmp++; if (proto_err !== 1'b0)  begin n_bad++; $display("FAIL reset_proto_err got %b want 0", proto_err); end
    n_cmp++; if (len_err !== 1'b0)    begin n_bad++; $display("FAIL reset_len_err got %b want 0", len_err); end
    mode = 2'b10; #1;
    n_cmp++; if (pad_out !== 4'h0)    begin n_bad++; $display("FAIL reset_extest_pad_out got %h want %h", pad_out, 4'h0); end
    n_cmp++; if (WPSO !== 1'b0)       begin n_bad++; $display("FAIL reset_wpso got %b want 0", WPSO); end
  endtask

  task automatic test_reset_mid_shift();
    do_reset();
    sh(1'b1); sh(1'b1); sh(1'b1);
    do_reset();
    for (int k = 0; k < L; k++) begin
      sh(1'b0);
      n_cmp++; if (WPSO !== exp_q[0]) begin n_bad++; $display("FAIL mid_shift_wpso[%0d] got %b want %b", k, WPSO, exp_q[0]); end
    end
  endtask

  task automatic test_extest();
    do_reset();
    mode = 2'b10;
    shift_word(7'b1010011);
    upd();
    n_cmp++; if (pad_out !== 4'b0011) begin n_bad++; $display("FAIL extest_pad_out got %b want %b", pad_out, 4'b0011); end
    n_cmp++; if (core_in !== 3'b000)  begin n_bad++; $display("FAIL extest_core_in got %b want %b", core_in, 3'b000); end
    n_cmp++; if (len_err !== 1'b0)    begin n_bad++; $display("FAIL extest_len_err got %b want 0", len_err); end
    n_cmp++; if (WPSO !== exp_q[0])   begin n_bad++; $display("FAIL extest_wpso got %b want %b", WPSO, exp_q[0]); end
  endtask

  task automatic test_capture();
    logic [6:0] seq;
    logic w;
    seq = 7'b1011010;
    core_out = 4'hA; pad_in = 3'b101;
    cap();
    n_cmp++; if (WPSO !== seq[0]) begin n_bad++; $display("FAIL capture_wpso[0] got %b want %b", WPSO, seq[0]); end
    for (int k = 1; k < L; k++) begin
      w = 1'($urandom_range(0, 1));
      sh(w);
      n_cmp++; if (WPSO !== seq[k]) begin n_bad++; $display("FAIL capture_wpso[%0d] got %b want %b", k, WPSO, seq[k]); end
    end
    // bits entered on WPSI during the unload now emerge L shifts later
    for (int k = 0; k < 2*L; k++) begin
      w = 1'($urandom_range(0, 1));
      sh(w);
      n_cmp++; if (WPSO !== exp_q[0]) begin n_bad++; $display("FAIL stream_wpso[%0d] got %b want %b", k, WPSO, exp_q[0]); end
    end
  endtask

  task automatic test_intest();
    do_reset();
    mode = 2'b00;
    shift_word(7'b1100101);
    upd();
    mode = 2'b01; #1;
    n_cmp++; if (core_in !== 3'b110)  begin n_bad++; $display("FAIL intest_core_in got %b want %b", core_in, 3'b110); end
    n_cmp++; if (pad_out !== 4'h0)    begin n_bad++; $display("FAIL intest_pad_out got %h want %h", pad_out, 4'h0); end
    mode = 2'b10; #1;
    n_cmp++; if (pad_out !== 4'b0101) begin n_bad++; $display("FAIL intest_then_extest_pad_out got %b want %b", pad_out, 4'b0101); end
    n_cmp++; if (WPSO !== exp_q[0])   begin n_bad++; $display("FAIL intest_wpso got %b want %b", WPSO, exp_q[0]); end
  endtask

  task automatic test_bus_disable();
    mode = 2'b00; core_out = 4'h5; pad_in = 3'b011; BusDisable = 1'b1; #1;
    n_cmp++; if (pad_oe !== 4'b0111)  begin n_bad++; $display("FAIL busdis_pad_oe got %b want %b", pad_oe, 4'b0111); end
    n_cmp++; if (pad_out !== 4'h5)    begin n_bad++; $display("FAIL busdis_pad_out got %h want %h", pad_out, 4'h5); end
    n_cmp++; if (core_in !== 3'b011)  begin n_bad++; $display("FAIL func_core_in got %b want %b", core_in, 3'b011); end
    BusDisable = 1'b0; #1;
    n_cmp++; if (pad_oe !== 4'b1111)  begin n_bad++; $display("FAIL func_pad_oe got %b want %b", pad_oe, 4'b1111); end
    mode = 2'b11; #1;
    n_cmp++; if (pad_oe !== 4'b0111)  begin n_bad++; $display("FAIL safe_pad_oe got %b want %b", pad_oe, 4'b0111); end
    n_cmp++; if (core_in !== 3'b000)  begin n_bad++; $display("FAIL safe_core_in got %b want %b", core_in, 3'b000); end
    n_cmp++; if (pad_out !== 4'h0)    begin n_bad++; $display("FAIL safe_pad_out got %h want %h", pad_out, 4'h0); end
  endtask

  task automatic test_errors();
    do_reset();
    mode = 2'b10;
    shift_word(7'b0001111);
    upd();
    // shift and update together: only the shift happens
    tick(1'b1, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(1'b1);
    void'(exp_q.pop_front());
    n_cmp++; if (pad_out !== 4'b1111) begin n_bad++; $display("FAIL proto_ureg_kept got %b want %b", pad_out, 4'b1111); end
    n_cmp++; if (proto_err !== 1'b1)  begin n_bad++; $display("FAIL proto_err_set got %b want 1", proto_err); end
    n_cmp++; if (WPSO !== exp_q[0])   begin n_bad++; $display("FAIL proto_shift_done got %b want %b", WPSO, exp_q[0]); end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (proto_err !== 1'b1)  begin n_bad++; $display("FAIL proto_err_sticky got %b want 1", proto_err); end
    do_reset();
    n_cmp++; if (proto_err !== 1'b0)  begin n_bad++; $display("FAIL proto_err_cleared got %b want 0", proto_err); end
    core_out = 4'h0; pad_in = 3'b110;
    cap();
    sh(1'b1); sh(1'b0); sh(1'b1); sh(1'b0); sh(1'b1);
    upd();
    n_cmp++; if (len_err !== 1'b1)    begin n_bad++; $display("FAIL len_err_short got %b want 1", len_err); end
    n_cmp++; if (pad_out !== 4'b0111) begin n_bad++; $display("FAIL len_err_ureg_out got %b want %b", pad_out, 4'b0111); end
    mode = 2'b01; #1;
    n_cmp++; if (core_in !== 3'b101)  begin n_bad++; $display("FAIL len_err_ureg_in got %b want %b", core_in, 3'b101); end
    n_cmp++; if (proto_err !== 1'b0)  begin n_bad++; $display("FAIL no_proto_err got %b want 0", proto_err); end
    do_reset();
    n_cmp++; if (len_err !== 1'b0)    begin n_bad++; $display("FAIL len_err_cleared got %b want 0", len_err); end
  endtask

  task automatic test_counter();
    // 23 shifts would wrap a 4-bit counter to 7 without saturation
    do_reset();
    for (int k = 0; k < 23; k++) sh(1'b0);
    upd();
    n_cmp++; if (len_err !== 1'b1) begin n_bad++; $display("FAIL cnt_saturate got %b want 1", len_err); end
    do_reset();
    for (int k = 0; k < 8; k++) sh(1'b0);
    upd();
    n_cmp++; if (len_err !== 1'b1) begin n_bad++; $display("FAIL cnt_one_over got %b want 1", len_err); end
    do_reset();
    sh(1'b1); sh(1'b1); sh(1'b1);
    cap();
    for (int k = 0; k < L; k++) sh(1'b0);
    upd();
    n_cmp++; if (len_err !== 1'b0) begin n_bad++; $display("FAIL cnt_cleared_by_capture got %b want 0", len_err); end
    upd();
    n_cmp++; if (len_err !== 1'b1) begin n_bad++; $display("FAIL back_to_back_update got %b want 1", len_err); end
    do_reset();
    upd();
    n_cmp++; if (len_err !== 1'b1) begin n_bad++; $display("FAIL update_after_reset got %b want 1", len_err); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_shift();
    test_extest();
    test_capture();
    test_intest();
    test_bus_disable();
    test_errors();
    test_counter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wbr_param.md
# wbr_param

Parametrised IEEE 1500 wrapper boundary register: a single chain of NUM_OUT core-output cells and NUM_IN core-input cells, each with a shift stage and an update stage.
- Supports four wrapper modes: functional, internal test, external test and safe.
- Has per-cell bus-disable gating and sticky protocol/length error flags.
- Sits between a core and its pads and replaces fixed-cell hand-built boundary registers; the wrapper instruction register drives it.

## Interface
- NUM_OUT, default 4: number of core-output (pad-driving) cells.
- NUM_IN, default 3: number of core-input cells.
- OE_MASK, default 4'b1000: NUM_OUT bits; a set bit makes that output cell a gated (bus-disable) cell.
- SAFE_OUT, default '0: NUM_OUT bits; value driven to pads in safe/intest modes and update-stage reset value.
- SAFE_IN, default '0: NUM_IN bits; value driven to core in safe/extest modes and update-stage reset value.
- CLK  in  1  wrapper clock; single clock domain.
- resetn  in  1  synchronous, active-low reset.
- WPSI  in  1  serial scan in.
- WPSO  out  1  serial scan out.
- shift_wr  in  1  shift chain one position.
- capture_wr  in  1  parallel capture into shift stage.
- update_wr  in  1  copy shift stage into update stage.
- mode  in  2  00 functional, 01 intest, 10 extest, 11 safe.
- BusDisable  in  1  forces gated cells' pad_oe low.
- core_out  in  NUM_OUT  core functional outputs.
- pad_out  out  NUM_OUT  to pads.
- pad_oe  out  NUM_OUT  pad output enables.
- pad_in  in  NUM_IN  from pads.
- core_in  out  NUM_IN  to core functional inputs.
- proto_err  out  1  sticky: more than one of shift/capture/update asserted in one cycle.
- len_err  out  1  sticky: update with shift count ≠ L.

## Operation
- L = NUM_OUT + NUM_IN. Shift stage sreg[L-1:0], update stage ureg[L-1:0].
- sreg[i] for i < NUM_OUT is output cell i; sreg[NUM_OUT+j] is input cell j.
- Chain: WPSI → sreg[L-1] → … → sreg[0] → WPSO. WPSO = sreg[0], registered.
- Shift: sreg <= {WPSI, sreg[L-1:1]}.
- Capture: output cells load core_out; input cells load pad_in (all modes).
- Update: ureg <= sreg.
- Priority when simultaneous: shift > capture > update. Only the winner executes; proto_err is set.
- Shift counter shift_cnt, width clog2(L+2): saturates at L+1 and clears on capture or update.
  - On update_wr with shift_cnt ≠ L, set len_err; the update still commits.
- Output mux (combinational), by mode:
  - functional: pad_out = core_out, core_in = pad_in.
  - intest: pad_out = SAFE_OUT, core_in = ureg input cells.
  - extest: pad_out = ureg output cells, core_in = SAFE_IN.
  - safe: pad_out = SAFE_OUT, core_in = SAFE_IN.
- pad_oe[i] = 0 if OE_MASK[i] and (BusDisable or mode == safe); otherwise 1.
- Mode changes take effect combinationally. Changing mode never alters sreg or ureg.

## Timing
- Reset (resetn low at a CLK edge):
  - sreg = 0, WPSO = 0.
  - ureg = {SAFE_IN, SAFE_OUT}.
  - shift_cnt = 0, proto_err = 0, len_err = 0.
  - Reset overrides any concurrent shift/capture/update.
  - Reset mid-shift discards partial data.
- Capture at edge n: captured bit 0 is on WPSO after edge n.
- k-th shift after capture: WPSO shows captured bit k.
- Bit loaded from WPSI at shift edge n appears on WPSO after L shifts.
- Update at edge n: pad_out/core_in reflect new ureg after edge n (zero added latency).
- Error flags assert the cycle after the offending edge and hold until reset.

## Structure
- Package wbr_pkg holds:
  - mode constants MODE_FUNC/MODE_INTEST/MODE_EXTEST/MODE_SAFE;
  - the 2-bit mode typedef;
  - a clog2-based counter-width function.
- Sub-module wbr_cell: one shift flop plus one update flop with capture/shift/update muxing and a per-cell reset value. Instantiate L times via generate.
- Mode mux, OE gating, counter and error flags live in the top.

## Test plan
- Reset: in safe mode, pad_out = SAFE_OUT and pad_oe[3] = 0. Switch to extest after reset: pad_out = SAFE_OUT, WPSO = 0.
- EXTEST drive: shift 7'b1010011 (LSB first), update, mode = 10 → pad_out = 4'b0011, core_in = SAFE_IN, len_err = 0.
- Capture/observe: core_out = 4'hA, pad_in = 3'b101, capture, 7 shifts → WPSO sequence 0,1,0,1,1,0,1.
- INTEST: shift so input cells = 3'b110, update, mode = 01 → core_in = 3'b110, pad_out = SAFE_OUT.
- BusDisable: functional mode, BusDisable = 1 → pad_oe = 4'b0111, pad_out = core_out.
- Errors:
  - shift_wr and update_wr in the same cycle → shift only, ureg unchanged, proto_err = 1.
  - capture, 5 shifts, update → len_err = 1, ureg updated.
  - reset clears both flags.
